// File: rtl/coeff_replay_fifo.sv
// Circular coefficient FIFO with a replay window. Words read since the last commit stay in
// storage so the consumer can rewind (redo) and re-stream them; commit frees them.
module coeff_replay_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter logic [31:0] MARKER = 32'h7F900000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en,
  input  logic              redo_i,
  input  logic              commit_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   unread_o,
  output logic [ADDR_W:0]   occ_o,
  output logic              start_o,
  output logic [ADDR_W-1:0] wr_out,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned PtrW  = ADDR_W + 1;
  localparam logic [PtrW-1:0]   DepthP  = PtrW'(Depth);
  localparam logic [DATA_W-1:0] MarkerW = DATA_W'(MARKER);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   base_ptr_q, base_ptr_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mem_q [Depth];

  logic is_marker;
  logic wr_acc;
  logic rd_acc;

  // Flags derive only from registered pointers.
  always_comb begin
    occ_o    = wr_ptr_q - base_ptr_q;
    unread_o = wr_ptr_q - rd_ptr_q;
    full_o   = (occ_o == DepthP);
    empty_o  = (wr_ptr_q == rd_ptr_q);
    wr_out   = wr_ptr_q[ADDR_W-1:0];
    valid_o  = valid_q;
    start_o  = start_q;
    data_o   = data_q;
  end

  always_comb begin
    is_marker = (data_i == MarkerW);
    wr_acc    = wr_en & ~full_o & ~is_marker;
    rd_acc    = rd_en & ~empty_o & ~redo_i;

    wr_ptr_d = wr_acc ? wr_ptr_q + PtrW'(1) : wr_ptr_q;

    if (redo_i) begin
      rd_ptr_d = base_ptr_q;
    end else if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Committing alongside a read also releases the word being read.
    base_ptr_d = (commit_i & ~redo_i) ? rd_ptr_d : base_ptr_q;

    start_d = wr_en & is_marker;
    valid_d = rd_acc;
    data_d  = rd_acc ? mem_q[rd_ptr_q[ADDR_W-1:0]] : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      base_ptr_q <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      base_ptr_q <= base_ptr_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      data_q     <= data_d;
    end
  end

  // Storage is never cleared; reset only discards pointers.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_coeff_replay_fifo.sv
// Directed and randomized bench for coeff_replay_fifo against a queue-based model of the
// retained window.
module tb_coeff_replay_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] MK = 32'h7F900000;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          rd_en = 1'b0;
  logic          redo_i = 1'b0;
  logic          commit_i = 1'b0;
  logic          full_o, empty_o, start_o, valid_o;
  logic [AW:0]   unread_o, occ_o;
  logic [AW-1:0] wr_out;
  logic [DW-1:0] data_o;

  coeff_replay_fifo #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .MARKER(MK)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .wr_en   (wr_en),
    .data_i  (data_i),
    .rd_en   (rd_en),
    .redo_i  (redo_i),
    .commit_i(commit_i),
    .full_o  (full_o),
    .empty_o (empty_o),
    .unread_o(unread_o),
    .occ_o   (occ_o),
    .start_o (start_o),
    .wr_out  (wr_out),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  always #5 clk = ~clk;

  // Model: retained words in order, plus how many of them have been read.
  logic [DW-1:0] win_q[$];
  int            rd_idx = 0;
  int            wr_cnt = 0;
  logic          m_valid = 1'b0;
  logic          m_start = 1'b0;
  logic [DW-1:0] m_data = '0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid_o", 64'(valid_o), 64'(m_valid));
    check("data_o", 64'(data_o), 64'(m_data));
    check("start_o", 64'(start_o), 64'(m_start));
    check("full_o", 64'(full_o), 64'(win_q.size() == DEPTH));
    check("empty_o", 64'(empty_o), 64'(rd_idx == win_q.size()));
    check("unread_o", 64'(unread_o), 64'(win_q.size() - rd_idx));
    check("occ_o", 64'(occ_o), 64'(win_q.size()));
    check("wr_out", 64'(wr_out), 64'(wr_cnt % DEPTH));
  endtask

  task automatic step(input logic rn, input logic w, input logic [DW-1:0] d, input logic r,
                      input logic rdo, input logic cm);
    bit full, empty, mark, wacc, racc;
    rstn_i = rn; wr_en = w; data_i = d; rd_en = r; redo_i = rdo; commit_i = cm;
    @(posedge clk);
    if (!rn) begin
      win_q.delete();
      rd_idx = 0; wr_cnt = 0; m_valid = 1'b0; m_start = 1'b0; m_data = '0;
    end else begin
      full  = (win_q.size() == DEPTH);
      empty = (rd_idx == win_q.size());
      mark  = w && (d == MK);
      wacc  = w && !full && !mark;
      racc  = r && !empty && !rdo;
      m_start = mark;
      m_valid = racc;
      if (racc) m_data = win_q[rd_idx];
      if (rdo) rd_idx = 0;
      else if (racc) rd_idx++;
      if (cm && !rdo) begin
        for (int k = 0; k < rd_idx; k++) void'(win_q.pop_front());
        rd_idx = 0;
      end
      if (wacc) begin
        win_q.push_back(d);
        wr_cnt++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic wr(input logic [DW-1:0] d); step(1, 1, d, 0, 0, 0); endtask
  task automatic rd(); step(1, 0, '0, 1, 0, 0); endtask
  task automatic idle(); step(1, 0, '0, 0, 0, 0); endtask
  task automatic commit(); step(1, 0, '0, 0, 0, 1); endtask

  initial begin
    // Reset
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    check("rst_empty", 64'(empty_o), 64'd1);

    // Fill / drain
    for (int i = 1; i <= 16; i++) wr(DW'(i));
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_occ", 64'(occ_o), 64'd16);
    wr(32'h11);
    check("drop_occ", 64'(occ_o), 64'd16);
    for (int i = 1; i <= 16; i++) begin
      rd();
      check("drain_data", 64'(data_o), 64'(i));
    end
    check("drain_empty", 64'(empty_o), 64'd1);
    check("drain_occ", 64'(occ_o), 64'd16);
    commit();
    check("commit_occ", 64'(occ_o), 64'd0);
    check("commit_full", 64'(full_o), 64'd0);

    // Replay
    wr(32'hA); wr(32'hB); wr(32'hC);
    for (int p = 0; p < 4; p++) begin
      if (p > 0) step(1, 0, '0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
        rd();
        check("replay_data", 64'(data_o), 64'(32'hA + k));
      end
    end
    commit();

    // Wrap-around: write + read + commit every cycle
    for (int i = 0; i < 40; i++) begin
      step(1, 1, DW'(32'h100 + i), 1, 0, 1);
      check("wrap_occ", 64'(occ_o <= 1), 64'd1);
    end
    step(1, 0, '0, 1, 0, 1);
    check("wrap_last", 64'(data_o), 64'h127);

    // Marker
    wr(32'h1);
    wr(MK);
    check("mk_start", 64'(start_o), 64'd1);
    wr(32'h2);
    check("mk_start_off", 64'(start_o), 64'd0);
    check("mk_occ", 64'(occ_o), 64'd2);
    rd(); rd();
    commit();
    for (int i = 0; i < 16; i++) wr(DW'(32'h200 + i));
    wr(MK);
    check("mk_full_start", 64'(start_o), 64'd1);
    for (int i = 0; i < 16; i++) rd();
    commit();

    // Priority: redo beats read and commit
    wr(32'h31); wr(32'h32); wr(32'h33);
    rd(); rd();
    step(1, 0, '0, 1, 1, 1);
    check("prio_valid", 64'(valid_o), 64'd0);
    check("prio_occ", 64'(occ_o), 64'd3);
    rd();
    check("prio_first", 64'(data_o), 64'h31);
    step(1, 0, '0, 1, 0, 1);
    check("rdcommit_occ", 64'(occ_o), 64'd1);
    rd(); commit();

    // Reset mid-stream
    for (int i = 0; i < 5; i++) wr(DW'(32'h40 + i));
    rd(); rd();
    step(0, 0, '0, 1, 0, 0);
    check("mrst_valid", 64'(valid_o), 64'd0);
    check("mrst_occ", 64'(occ_o), 64'd0);
    wr(32'h55);
    rd();
    check("mrst_55", 64'(data_o), 64'h55);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic          w, r, rdo, cm, rn;
      logic [DW-1:0] d;
      rn  = ($urandom_range(0, 199) != 0);
      w   = ($urandom_range(0, 9) < 6);
      d   = ($urandom_range(0, 19) == 0) ? MK : DW'($urandom);
      r   = ($urandom_range(0, 9) < 5);
      rdo = ($urandom_range(0, 19) == 0);
      cm  = ($urandom_range(0, 9) == 0);
      step(rn, w, d, r, rdo, cm);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
